// File: rtl/harness_pkg.sv
// Shared types and constants for the hash core harness.
package harness_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    RESET = 3'd2,
    RUN   = 3'd3,
    DONE  = 3'd4
  } state_t;

  // debug_o word selects
  localparam logic [1:0] DBG_CYCLES  = 2'd0;
  localparam logic [1:0] DBG_HASH_LO = 2'd1;
  localparam logic [1:0] DBG_HASH_HI = 2'd2;
  localparam logic [1:0] DBG_STATUS  = 2'd3;

endpackage

// File: rtl/harness_lat_counter.sv
// Latency counter for one hash run. count_o already includes the current
// cycle, so the first enabled cycle reads as 1; timeout_o flags the cycle
// whose count equals TIMEOUT_CYCLES.
module harness_lat_counter #(
  parameter int CNT_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear_i,
  input  logic                 enable_i,
  output logic [CNT_WIDTH-1:0] count_o,
  output logic                 timeout_o
);

  localparam logic [CNT_WIDTH-1:0] TIMEOUT_VAL = CNT_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [CNT_WIDTH-1:0] ONE         = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;

  assign count_o   = cnt_q + ONE;
  assign timeout_o = enable_i && (count_o == TIMEOUT_VAL);

  // Next count: clear has priority over counting
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = count_o;
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/hash_uut_harness.sv
// Bridge between the autotest engine and NUM_UUT hash cores: generates the
// per-core reset window, launches the selected core, measures latency,
// enforces a timeout and exposes a debug word.
module hash_uut_harness
  import harness_pkg::*;
#(
  parameter int MSG_WIDTH      = 64,
  parameter int HASH_WIDTH     = 88,
  parameter int NUM_UUT        = 2,
  parameter int RST_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int CNT_WIDTH      = 32,
  parameter int SEL_W          = (NUM_UUT > 1) ? $clog2(NUM_UUT) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       run_rst_i,
  input  logic [MSG_WIDTH-1:0]       msg_i,
  input  logic [SEL_W-1:0]           sel_i,
  output logic [NUM_UUT-1:0]         uut_rst_o,
  output logic [MSG_WIDTH-1:0]       uut_msg_o,
  input  logic [NUM_UUT-1:0]         uut_end_i,
  input  logic [NUM_UUT*HASH_WIDTH-1:0] uut_hash_i,
  output logic                       end_o,
  output logic                       err_o,
  output logic [HASH_WIDTH-1:0]      hash_o,
  output logic [CNT_WIDTH-1:0]       cycles_o,
  input  logic [1:0]                 dbg_sel_i,
  output logic [31:0]                debug_o
);

  localparam int RCW = $clog2(RST_CYCLES + 1);

  state_t                 state_q;
  logic [SEL_W-1:0]       sel_q;
  logic [SEL_W-1:0]       sel_d;
  logic [RCW-1:0]         rst_cnt_q;
  logic [MSG_WIDTH-1:0]   msg_q;
  logic [HASH_WIDTH-1:0]  hash_q;
  logic [CNT_WIDTH-1:0]   cycles_q;
  logic                   end_q;
  logic                   err_q;
  logic [15:0]            run_cnt_q;
  logic [7:0]             err_cnt_q;

  logic [HASH_WIDTH-1:0]  hash_sel;
  logic                   end_sel;
  logic [CNT_WIDTH-1:0]   lat_cnt;
  logic                   lat_timeout;

  harness_lat_counter #(
    .CNT_WIDTH      (CNT_WIDTH),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_lat (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (state_q != RUN),
    .enable_i  (state_q == RUN),
    .count_o   (lat_cnt),
    .timeout_o (lat_timeout)
  );

  // Out-of-range core selects fall back to core 0
  always_comb begin
    sel_d = (32'(sel_i) < 32'(NUM_UUT)) ? sel_i : '0;
  end

  // Route the selected core's end/hash; other cores are ignored
  always_comb begin
    hash_sel = '0;
    end_sel  = 1'b0;
    for (int unsigned k = 0; k < NUM_UUT; k++) begin
      if (sel_q == SEL_W'(k)) begin
        hash_sel = uut_hash_i[k*HASH_WIDTH +: HASH_WIDTH];
        end_sel  = uut_end_i[k];
      end
    end
  end

  // Only the selected core is released, and only while running or done
  always_comb begin
    uut_rst_o = '1;
    for (int unsigned k = 0; k < NUM_UUT; k++) begin
      if ((state_q == RUN || state_q == DONE) && sel_q == SEL_W'(k)) begin
        uut_rst_o[k] = 1'b0;
      end
    end
  end

  // Run control FSM with capture registers and run statistics
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      rst_cnt_q <= '0;
      msg_q     <= '0;
      hash_q    <= '0;
      cycles_q  <= '0;
      end_q     <= 1'b0;
      err_q     <= 1'b0;
      run_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (run_rst_i) begin
            state_q <= ARM;
            end_q   <= 1'b0;
            err_q   <= 1'b0;
          end
        end
        ARM: begin
          msg_q <= msg_i;
          sel_q <= sel_d;
          if (!run_rst_i) begin
            state_q   <= RESET;
            rst_cnt_q <= RCW'(RST_CYCLES);
          end
        end
        RESET: begin
          if (run_rst_i) begin
            state_q <= ARM;
          end else if (rst_cnt_q == RCW'(1)) begin
            state_q <= RUN;
          end else begin
            rst_cnt_q <= rst_cnt_q - RCW'(1);
          end
        end
        RUN: begin
          // abort beats completion; completion beats timeout
          if (run_rst_i) begin
            state_q <= ARM;
          end else if (end_sel) begin
            hash_q    <= hash_sel;
            cycles_q  <= lat_cnt;
            end_q     <= 1'b1;
            err_q     <= 1'b0;
            run_cnt_q <= run_cnt_q + 16'd1;
            state_q   <= DONE;
          end else if (lat_timeout) begin
            hash_q    <= '0;
            cycles_q  <= CNT_WIDTH'(TIMEOUT_CYCLES);
            end_q     <= 1'b1;
            err_q     <= 1'b1;
            err_cnt_q <= err_cnt_q + 8'd1;
            run_cnt_q <= run_cnt_q + 16'd1;
            state_q   <= DONE;
          end
        end
        DONE: begin
          if (run_rst_i) begin
            state_q <= ARM;
            end_q   <= 1'b0;
            err_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign uut_msg_o = msg_q;
  assign end_o     = end_q;
  assign err_o     = err_q;
  assign hash_o    = hash_q;
  assign cycles_o  = cycles_q;

  // Debug word mux for the 7-segment display
  always_comb begin
    debug_o = '0;
    case (dbg_sel_i)
      DBG_CYCLES:  debug_o = 32'(cycles_q);
      DBG_HASH_LO: debug_o = hash_q[31:0];
      DBG_HASH_HI: debug_o = hash_q[63:32];
      DBG_STATUS:  debug_o = {run_cnt_q, err_cnt_q, 5'b0, state_q};
      default:     debug_o = '0;
    endcase
  end

endmodule
